// File: rtl/reversi_accel_hls_deadlock_monitor_unit.sv
// Per-process deadlock monitor for the HLS dataflow ring.
// Merges masked incoming dependence vectors, forwards this process's own
// dependence downstream, circulates the report token, and flags deadlock once
// the self-dependence has held for STABLE_CYCLES consecutive cycles.
module reversi_accel_hls_deadlock_monitor_unit #(
  parameter int PROC_NUM      = 4,
  parameter int PROC_ID       = 0,
  parameter int IN_CHAN_NUM   = 2,
  parameter int OUT_CHAN_NUM  = 3,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec,
  input  logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec,
  input  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec,
  input  logic [IN_CHAN_NUM-1:0]          in_chan_mask,
  input  logic [IN_CHAN_NUM-1:0]          token_in_vec,
  input  logic                            dl_detect_in,
  input  logic                            origin,
  input  logic                            token_clear,
  input  logic                            sticky_clr,
  output logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec,
  output logic [PROC_NUM-1:0]             out_chan_dep_data,
  output logic [OUT_CHAN_NUM-1:0]         token_out_vec,
  output logic                            dl_detect_out,
  output logic                            dl_sticky,
  output logic [IN_CHAN_NUM-1:0]          dl_chan_vec,
  output logic [CNT_W-1:0]                stall_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_DETECT = 2'd2
  } state_t;

  localparam logic [PROC_NUM-1:0] SELF_BIT = PROC_NUM'(1) << PROC_ID;
  localparam logic [CNT_W-1:0]    CNT_MAX  = '1;
  // Count value seen in the last ARMED cycle before detect is declared.
  localparam logic [CNT_W-1:0]    ARM_LAST = CNT_W'(STABLE_CYCLES - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [PROC_NUM-1:0]     r_dep;
  logic [CNT_W-1:0]        r_stall_cnt;
  logic                    r_sticky;
  logic [IN_CHAN_NUM-1:0]  r_chan_vec;
  logic [OUT_CHAN_NUM-1:0] r_token_out;

  logic [IN_CHAN_NUM-1:0]  w_eff;
  logic [IN_CHAN_NUM-1:0]  w_chan_self;
  logic [PROC_NUM-1:0]     w_dep_comb;
  logic [PROC_NUM-1:0]     w_dep;
  logic                    w_upd;
  logic                    w_blocked;
  logic                    w_hit;
  logic                    w_detect_entry;
  logic                    w_token_fwd;

  assign w_eff = in_chan_dep_vld_vec & ~in_chan_mask;

  // Merge the unmasked incoming dependence vectors; note which carry our own bit.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_dep_comb  = '0;
    w_chan_self = '0;
    for (int i = 0; i < IN_CHAN_NUM; i++) begin
      if (w_eff[i]) w_dep_comb = w_dep_comb | in_chan_dep_data_vec[i*PROC_NUM +: PROC_NUM];
      w_chan_self[i] = w_eff[i] & in_chan_dep_data_vec[i*PROC_NUM + PROC_ID];
    end
  end

  // Once a deadlock has been reported globally, only a token refreshes the view.
  assign w_upd     = ~dl_detect_in | (|token_in_vec);
  assign w_dep     = w_upd ? w_dep_comb : r_dep;
  assign w_blocked = |proc_dep_vld_vec;
  assign w_hit     = w_upd & w_dep[PROC_ID] & w_blocked;

  assign w_token_fwd = ((|token_in_vec) & ~token_clear) | origin;

  // Persistence FSM: next-state decision.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_hit) w_state_nxt = (STABLE_CYCLES == 1) ? S_DETECT : S_ARMED;
      S_ARMED:  if (!w_hit) w_state_nxt = S_IDLE;
                else if (r_stall_cnt == ARM_LAST) w_state_nxt = S_DETECT;
      S_DETECT: if (!w_hit) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  assign w_detect_entry = (w_state_nxt == S_DETECT) && (r_state != S_DETECT);

  // State register for the persistence FSM.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Held dependence vector; dropped as soon as this process is no longer blocked.
  always_ff @(posedge clock) begin
    if (!reset)         r_dep <= '0;
    else if (w_blocked) r_dep <= w_dep;
    else                r_dep <= '0;
  end

  // Consecutive-hit counter, saturating, cleared by any gap.
  always_ff @(posedge clock) begin
    if (!reset)                        r_stall_cnt <= '0;
    else if (!w_hit)                   r_stall_cnt <= '0;
    else if (r_stall_cnt != CNT_MAX)   r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

  // Debug capture: sticky flag (set beats clear) and contributing-channel snapshot.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sticky   <= 1'b0;
      r_chan_vec <= '0;
    end else if (w_detect_entry) begin
      r_sticky   <= 1'b1;
      r_chan_vec <= w_chan_self;
    end else if (sticky_clr) begin
      r_sticky   <= 1'b0;
    end
  end

  // Report token forwarded one cycle later on the channels we are blocked on.
  always_ff @(posedge clock) begin
    if (!reset)           r_token_out <= '0;
    else if (w_token_fwd) r_token_out <= proc_dep_vld_vec;
    else                  r_token_out <= '0;
  end

  assign out_chan_dep_vld_vec = proc_dep_vld_vec;
  assign out_chan_dep_data    = r_dep | SELF_BIT;
  assign token_out_vec        = r_token_out;
  assign dl_detect_out        = (r_state == S_DETECT);
  assign dl_sticky            = r_sticky;
  assign dl_chan_vec          = r_chan_vec;
  assign stall_cnt            = r_stall_cnt;

endmodule

// File: tb/tb_reversi_accel_hls_deadlock_monitor_unit.sv
// Self-checking bench for the per-process deadlock monitor (default parameters).
module tb_reversi_accel_hls_deadlock_monitor_unit;

  localparam int S = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] pdv;
  logic [1:0] vld;
  logic [7:0] data;
  logic [1:0] mask;
  logic [1:0] tok;
  logic       dli, orig, tclr, sclr;

  logic [2:0] o_vld;
  logic [3:0] o_data;
  logic [2:0] o_tok;
  logic       o_det, o_sticky;
  logic [1:0] o_chan;
  logic [7:0] o_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  reversi_accel_hls_deadlock_monitor_unit dut (
    .clock(clock), .reset(reset),
    .proc_dep_vld_vec(pdv), .in_chan_dep_vld_vec(vld), .in_chan_dep_data_vec(data),
    .in_chan_mask(mask), .token_in_vec(tok), .dl_detect_in(dli), .origin(orig),
    .token_clear(tclr), .sticky_clr(sclr),
    .out_chan_dep_vld_vec(o_vld), .out_chan_dep_data(o_data), .token_out_vec(o_tok),
    .dl_detect_out(o_det), .dl_sticky(o_sticky), .dl_chan_vec(o_chan), .stall_cnt(o_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input logic [2:0] p, input logic [1:0] v, input logic [7:0] d,
                       input logic [1:0] m, input logic [1:0] t, input logic di,
                       input logic o, input logic tc, input logic sc);
    pdv = p; vld = v; data = d; mask = m; tok = t; dli = di; orig = o; tclr = tc; sclr = sc;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(3'b000, 2'b00, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
  endtask

  // Table of one-cycle vectors with expected registered outputs after the edge.
  typedef struct {
    logic [2:0] pdv;
    logic [1:0] vld;
    logic [7:0] data;
    logic [1:0] mask;
    logic [7:0] exp_cnt;
    logic       exp_det;
    logic       exp_sticky;
    logic [1:0] exp_chan;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [2:0] p, input logic [1:0] v, input logic [7:0] d,
                              input logic [1:0] m, input logic [7:0] c, input logic dt,
                              input logic st, input logic [1:0] ch);
    vec_t r;
    r.pdv = p; r.vld = v; r.data = d; r.mask = m;
    r.exp_cnt = c; r.exp_det = dt; r.exp_sticky = st; r.exp_chan = ch;
    return r;
  endfunction

  // Reference model: consecutive self-dependence run length, detect once it reaches S.
  logic [3:0] m_dep;
  int         m_run;
  logic       m_sticky;
  logic [1:0] m_chan;
  logic [2:0] m_tok;

  task automatic model_step();
    logic [1:0] eff;
    logic [3:0] comb, dep;
    logic       upd, hit;
    int         run_nxt;
    eff  = vld & ~mask;
    comb = (eff[0] ? data[3:0] : 4'h0) | (eff[1] ? data[7:4] : 4'h0);
    upd  = !dli || (tok != 2'b00);
    dep  = upd ? comb : m_dep;
    hit  = upd && dep[0] && (pdv != 3'b000);
    if (!reset) begin
      m_dep = '0; m_run = 0; m_sticky = 1'b0; m_chan = '0; m_tok = '0;
    end else begin
      run_nxt = hit ? m_run + 1 : 0;
      if (run_nxt == S) begin
        m_sticky = 1'b1;
        m_chan   = {eff[1] & data[4], eff[0] & data[0]};
      end else if (sclr) begin
        m_sticky = 1'b0;
      end
      m_run = run_nxt;
      m_dep = (pdv != 3'b000) ? dep : 4'h0;
      m_tok = (((tok != 2'b00) && !tclr) || orig) ? pdv : 3'b000;
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(3'b000, 2'b00, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset with every input active.
    reset = 1'b0;
    drive(3'b111, 2'b11, 8'hFF, 2'b00, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); tick();
    check("rst_det", o_det, 0);
    check("rst_sticky", o_sticky, 0);
    check("rst_chan", o_chan, 0);
    check("rst_cnt", o_cnt, 0);
    check("rst_tok", o_tok, 0);
    check("rst_data", o_data, 4'b0001);
    reset = 1'b1;
    drive(3'b000, 2'b00, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Persistence, then glitch, then mask: rows are consecutive cycles.
    for (int k = 1; k <= 4; k++) vecs.push_back(mk(3'b001, 2'b01, 8'h03, 2'b00, 8'(k), k == 4, k == 4, {1'b0, k == 4}));
    vecs.push_back(mk(3'b001, 2'b00, 8'h03, 2'b00, 8'd0, 1'b0, 1'b1, 2'b01));
    vecs.push_back(mk(3'b001, 2'b01, 8'h03, 2'b00, 8'd1, 1'b0, 1'b1, 2'b01));
    vecs.push_back(mk(3'b001, 2'b01, 8'h03, 2'b00, 8'd2, 1'b0, 1'b1, 2'b01));
    vecs.push_back(mk(3'b001, 2'b00, 8'h03, 2'b00, 8'd0, 1'b0, 1'b1, 2'b01));
    for (int k = 1; k <= 4; k++) vecs.push_back(mk(3'b001, 2'b01, 8'h03, 2'b00, 8'(k), k == 4, 1'b1, 2'b01));
    vecs.push_back(mk(3'b010, 2'b10, 8'h10, 2'b10, 8'd0, 1'b0, 1'b1, 2'b01));
    vecs.push_back(mk(3'b010, 2'b10, 8'h10, 2'b10, 8'd0, 1'b0, 1'b1, 2'b01));
    for (int k = 1; k <= 4; k++) vecs.push_back(mk(3'b010, 2'b10, 8'h10, 2'b00, 8'(k), k == 4, 1'b1, k == 4 ? 2'b10 : 2'b01));

    foreach (vecs[n]) begin
      drive(vecs[n].pdv, vecs[n].vld, vecs[n].data, vecs[n].mask, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      check($sformatf("vec%0d_cnt", n), o_cnt, vecs[n].exp_cnt);
      check($sformatf("vec%0d_det", n), o_det, vecs[n].exp_det);
      check($sformatf("vec%0d_sticky", n), o_sticky, vecs[n].exp_sticky);
      check($sformatf("vec%0d_chan", n), o_chan, vecs[n].exp_chan);
      check($sformatf("vec%0d_vld", n), o_vld, vecs[n].pdv);
    end

    // Token path and held dependence while a deadlock is already reported.
    do_reset();
    drive(3'b001, 2'b01, 8'h03, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("tok_dep_loaded", o_data, 4'b0011);
    check("tok_idle", o_tok, 0);
    drive(3'b001, 2'b00, 8'h00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("hold_dep", o_data, 4'b0011);
    check("hold_no_hit", o_cnt, 0);
    drive(3'b001, 2'b00, 8'h00, 2'b00, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    check("tok_cleared", o_tok, 0);
    check("tok_refresh_dep", o_data, 4'b0001);
    drive(3'b101, 2'b00, 8'h00, 2'b00, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    check("tok_origin", o_tok, 3'b101);
    drive(3'b110, 2'b00, 8'h00, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("tok_fwd", o_tok, 3'b110);

    // Sticky: set, then clear coinciding with a fresh DETECT entry, then clear alone.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(3'b001, 2'b11, 8'h11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    check("stk_set", o_sticky, 1);
    check("stk_chan", o_chan, 2'b11);
    drive(3'b001, 2'b00, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(3'b001, 2'b01, 8'h11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, k == 3);
      tick();
    end
    check("stk_set_wins", o_sticky, 1);
    check("stk_det", o_det, 1);
    check("stk_chan2", o_chan, 2'b01);
    drive(3'b001, 2'b00, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("stk_cleared", o_sticky, 0);

    // Reset in the middle of a detect.
    for (int k = 0; k < 5; k++) begin
      drive(3'b011, 2'b01, 8'h01, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    check("mid_det", o_det, 1);
    reset = 1'b0;
    tick();
    check("mid_rst_det", o_det, 0);
    check("mid_rst_cnt", o_cnt, 0);
    check("mid_rst_sticky", o_sticky, 0);
    check("mid_rst_tok", o_tok, 0);
    reset = 1'b1;

    // Randomised run against the reference model.
    do_reset();
    m_dep = '0; m_run = 0; m_sticky = 1'b0; m_chan = '0; m_tok = '0;
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 63) != 0);
      pdv   = ($urandom_range(0, 7) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
      vld   = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b11;
      data  = 8'($urandom);
      if ($urandom_range(0, 7) != 0) data[0] = 1'b1;
      mask  = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00;
      tok   = 2'($urandom);
      dli   = ($urandom_range(0, 7) == 0);
      orig  = ($urandom_range(0, 3) == 0);
      tclr  = ($urandom_range(0, 3) == 0);
      sclr  = ($urandom_range(0, 11) == 0);
      model_step();
      tick();
      check("rnd_cnt", o_cnt, (m_run > 255) ? 255 : m_run);
      check("rnd_det", o_det, m_run >= S);
      check("rnd_sticky", o_sticky, m_sticky);
      check("rnd_chan", o_chan, m_chan);
      check("rnd_tok", o_tok, m_tok);
      check("rnd_data", o_data, m_dep | 4'b0001);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reversi_accel_hls_deadlock_monitor_unit.md
Name: reversi_accel_hls_deadlock_monitor_unit

Overview:
Per-process deadlock monitor for the HLS dataflow region. It is the parametrised successor of the per-process dependence/token detect unit and is instantiated once per process in the same ring.
- Merges incoming channel dependence vectors, with a runtime per-channel mask.
- Forwards its own dependence on the outgoing channels and circulates the report token.
- Asserts deadlock only after the self-dependence has persisted STABLE_CYCLES consecutive cycles.
- Adds a sticky flag, a snapshot of the contributing channels and a stall counter for debug readout.

Parameters:
PROC_NUM, 4, number of processes in the dataflow region (dependence vector width)
PROC_ID, 0, index of this process; its bit is set in every outgoing dependence vector
IN_CHAN_NUM, 2, number of incoming dependence channels
OUT_CHAN_NUM, 3, number of outgoing dependence channels
STABLE_CYCLES, 4, consecutive self-dependence cycles required before detect; minimum 1
CNT_W, 8, width of stall counter; 2^CNT_W-1 must be >= STABLE_CYCLES

Ports:
clock  in  1  single clock, rising edge
reset  in  1  synchronous active-low reset
proc_dep_vld_vec  in  OUT_CHAN_NUM  this process blocked on outgoing channel j
in_chan_dep_vld_vec  in  IN_CHAN_NUM  incoming dependence valid per channel
in_chan_dep_data_vec  in  IN_CHAN_NUM*PROC_NUM  incoming dependence vectors, channel i at [i*PROC_NUM +: PROC_NUM]
in_chan_mask  in  IN_CHAN_NUM  1 = ignore channel i
token_in_vec  in  IN_CHAN_NUM  report token per incoming channel
dl_detect_in  in  1  global deadlock-reported flag
origin  in  1  this unit originates the token
token_clear  in  1  suppress token propagation this cycle
sticky_clr  in  1  clears dl_sticky
out_chan_dep_vld_vec  out  OUT_CHAN_NUM  outgoing dependence valid
out_chan_dep_data  out  PROC_NUM  outgoing dependence vector
token_out_vec  out  OUT_CHAN_NUM  registered token out
dl_detect_out  out  1  registered deadlock detect
dl_sticky  out  1  set on any detect, held until cleared
dl_chan_vec  out  IN_CHAN_NUM  channels carrying bit PROC_ID at detect entry
stall_cnt  out  CNT_W  consecutive hit cycles, saturating

Behaviour:
- Reset: synchronous, sampled at the rising clock edge while reset=0. It overrides every other input, including mid-detect. All registers go to 0 and the FSM goes to IDLE. dl_detect_out, dl_sticky, dl_chan_vec, stall_cnt, token_out_vec and the internal dep_reg are all 0. out_chan_dep_data then reads onehot(PROC_ID).
- Channel merge: eff[i] = in_chan_dep_vld_vec[i] & ~in_chan_mask[i]. dep_comb = OR over i of (eff[i] ? data_i : 0).
- Dependence select: upd = ~dl_detect_in | (|token_in_vec). dep = upd ? dep_comb : dep_reg.
- dep_reg update each cycle: dep if |proc_dep_vld_vec, else 0.
- Outputs (combinational): out_chan_dep_vld_vec = proc_dep_vld_vec. out_chan_dep_data = dep_reg | onehot(PROC_ID).
- Hit term: hit = upd & dep[PROC_ID] & (|proc_dep_vld_vec).
- stall_cnt: +1 when hit, saturating at 2^CNT_W-1. Set to 0 on any cycle without hit.
- FSM, states IDLE, ARMED, DETECT:
  - IDLE: if hit and STABLE_CYCLES==1, go to DETECT. If hit otherwise, go to ARMED.
  - ARMED: if !hit, go to IDLE. If hit and stall_cnt == STABLE_CYCLES-1, go to DETECT. Otherwise stay.
  - DETECT: stay while hit. If !hit, go to IDLE.
- dl_detect_out = (state==DETECT), registered. It rises exactly STABLE_CYCLES cycles after the first hit cycle.
- A gap of one non-hit cycle restarts the count from 0.
- On every transition into DETECT:
  - dl_chan_vec <= eff[i] & data_i[PROC_ID], per channel.
  - dl_sticky <= 1.
- dl_sticky is cleared by sticky_clr only when it is not being set that cycle; set wins on a simultaneous event.
- dl_chan_vec holds its value until the next DETECT entry or reset.
- Token: token_out_vec <= ((|token_in_vec & ~token_clear) | origin) ? proc_dep_vld_vec : 0. Latency is 1 cycle. origin overrides token_clear.
- in_chan_mask changes take effect combinationally in the same cycle. Masking the only contributing channel drops hit that cycle.

Test Plan:
- Reset: PROC_ID=0, drive reset=0 for 2 cycles with all inputs active -> all outputs 0; out_chan_dep_data=4'b0001 after release.
- Persistence, STABLE_CYCLES=4: proc_dep_vld_vec=3'b001, ch0 vld with data 4'b0011 from cycle 0 -> stall_cnt 1,2,3,4. dl_detect_out rises at edge 4. dl_chan_vec=2'b01, dl_sticky=1.
- Glitch: same stimulus with ch0 vld dropped at cycle 2 -> stall_cnt returns to 0, no detect. Detect occurs 4 cycles after hit resumes.
- Mask: ch1 data 4'b0001 valid, in_chan_mask=2'b10 -> no hit, stall_cnt stays 0. Clear the mask -> detect after 4 cycles, dl_chan_vec=2'b10.
- Token path: dl_detect_in=1, token_in_vec=0 -> dep held from dep_reg, no new hit. Then token_in_vec=2'b01 with token_clear=1 -> token_out_vec=0. With origin=1 -> token_out_vec=proc_dep_vld_vec next cycle.
- Sticky: set dl_sticky, then sticky_clr=1 on the same cycle as a new DETECT entry -> dl_sticky stays 1. sticky_clr=1 later with no detect entry -> dl_sticky=0.
